// File: rtl/cpu_selftest_checker.sv
// On-chip self-test checker: matches a programmable table of expected register writes,
// PC updates and halt against the live CPU ports, in order, and reports pass/fail/timeout.
module cpu_selftest_checker #(
    parameter int XLEN       = 32,
    parameter int NUM_CHECKS = 16,
    parameter int TIMEOUT_W  = 16,
    parameter int IDX_W      = $clog2(NUM_CHECKS + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [IDX_W-1:0]     exp_count,
    input  logic [TIMEOUT_W-1:0] timeout_cycles,
    input  logic                 tbl_we,
    input  logic [IDX_W-1:0]     tbl_idx,
    input  logic [1:0]           tbl_kind,
    input  logic [4:0]           tbl_reg,
    input  logic [XLEN-1:0]      tbl_val,
    input  logic                 rf_we,
    input  logic [4:0]           rf_waddr,
    input  logic [XLEN-1:0]      rf_wdata,
    input  logic                 pc_we,
    input  logic [XLEN-1:0]      pc,
    input  logic                 halted,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [1:0]           fail_code,
    output logic [IDX_W-1:0]     check_idx,
    output logic [XLEN-1:0]      fail_actual,
    output logic [15:0]          led
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_e;

    typedef struct packed {
        logic [1:0]      kind;
        logic [4:0]      rnum;
        logic [XLEN-1:0] val;
    } entry_t;

    localparam logic [1:0]       KIND_PC    = 2'b01;
    localparam logic [1:0]       FC_NONE    = 2'b00;
    localparam logic [1:0]       FC_MISM    = 2'b01;
    localparam logic [1:0]       FC_TIMEOUT = 2'b10;
    localparam logic [1:0]       FC_HALT    = 2'b11;
    localparam logic [IDX_W-1:0] MAX_COUNT  = IDX_W'(NUM_CHECKS);

    entry_t               tbl_q [NUM_CHECKS];
    entry_t               wr_entry;
    entry_t               cur_entry;

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [IDX_W-1:0]     exp_q, exp_d;
    logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
    logic [1:0]           fail_code_q, fail_code_d;
    logic [XLEN-1:0]      fail_actual_q, fail_actual_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 pass_q, pass_d;
    logic [15:0]          led_q, led_d;

    logic                 is_halt_entry;
    logic                 evt;
    logic                 evt_match;
    logic [XLEN-1:0]      evt_obs;
    logic [TIMEOUT_W-1:0] tmo_inc;
    logic [IDX_W-1:0]     exp_clamped;

    assign wr_entry = '{kind: tbl_kind, rnum: tbl_reg, val: tbl_val};

    // NOTE: the table is plain flops rather than RAM, so it is cleared by reset along with the FSM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CHECKS; i++) tbl_q[i] <= '0;
        end else if (tbl_we && state_q != S_RUN) begin
            for (int i = 0; i < NUM_CHECKS; i++) begin
                if (tbl_idx == IDX_W'(i)) tbl_q[i] <= wr_entry;
            end
        end
    end

    // Out-of-range indices select nothing, so they fall back to an all-zero entry.
    always_comb begin
        cur_entry = '0;
        for (int i = 0; i < NUM_CHECKS; i++) begin
            if (idx_q == IDX_W'(i)) cur_entry = tbl_q[i];
        end
    end

    always_comb begin
        is_halt_entry = cur_entry.kind[1];
        evt           = 1'b0;
        evt_obs       = '0;
        if (is_halt_entry) begin
            evt = halted;
        end else if (cur_entry.kind == KIND_PC) begin
            evt     = pc_we;
            evt_obs = pc;
        end else begin
            evt     = rf_we && (rf_waddr == cur_entry.rnum) && (rf_waddr != 5'd0);
            evt_obs = rf_wdata;
        end
        evt_match = is_halt_entry || (evt_obs == cur_entry.val);
    end

    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        exp_d         = exp_q;
        tmo_d         = tmo_q;
        fail_code_d   = fail_code_q;
        fail_actual_d = fail_actual_q;
        tmo_inc       = (&tmo_q) ? tmo_q : tmo_q + TIMEOUT_W'(1);
        exp_clamped   = (exp_count > MAX_COUNT) ? MAX_COUNT : exp_count;

        case (state_q)
            S_RUN: begin
                if (halted && !is_halt_entry) begin
                    state_d     = S_FAIL;
                    fail_code_d = FC_HALT;
                end else if (evt) begin
                    if (evt_match) begin
                        idx_d = idx_q + IDX_W'(1);
                        tmo_d = '0;
                        if (idx_d == exp_q) state_d = S_PASS;
                    end else begin
                        state_d       = S_FAIL;
                        fail_code_d   = FC_MISM;
                        fail_actual_d = evt_obs;
                    end
                end else begin
                    tmo_d = tmo_inc;
                    if (timeout_cycles != '0 && tmo_inc == timeout_cycles) begin
                        state_d     = S_FAIL;
                        fail_code_d = FC_TIMEOUT;
                    end
                end
            end
            default: begin
                if (start) begin
                    idx_d         = '0;
                    tmo_d         = '0;
                    exp_d         = exp_clamped;
                    fail_code_d   = FC_NONE;
                    fail_actual_d = '0;
                    state_d       = (exp_clamped == '0) ? S_PASS : S_RUN;
                end
            end
        endcase

        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_PASS) || (state_d == S_FAIL);
        pass_d = (state_d == S_PASS);
        led_d  = {pass_d, state_d == S_FAIL, fail_code_d, 4'(idx_d), fail_actual_d[7:0]};
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            idx_q         <= '0;
            exp_q         <= '0;
            tmo_q         <= '0;
            fail_code_q   <= FC_NONE;
            fail_actual_q <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            led_q         <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            exp_q         <= exp_d;
            tmo_q         <= tmo_d;
            fail_code_q   <= fail_code_d;
            fail_actual_q <= fail_actual_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            pass_q        <= pass_d;
            led_q         <= led_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign fail_code   = fail_code_q;
    assign check_idx   = idx_q;
    assign fail_actual = fail_actual_q;
    assign led         = led_q;

endmodule
